// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with two combinational read ports
// and one write port. Writes can be forwarded to the read ports in the same
// cycle. A per-register busy scoreboard lets the hazard unit stall on
// operands that are still waiting to be written back.
module regfile_sb #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [ADDR_WIDTH-1:0]       rd1,
    output logic [DATA_WIDTH-1:0]       rd1_data,
    output logic                        rd1_busy,
    input  logic [ADDR_WIDTH-1:0]       rd2,
    output logic [DATA_WIDTH-1:0]       rd2_data,
    output logic                        rd2_busy,
    input  logic [ADDR_WIDTH-1:0]       wr1,
    input  logic [DATA_WIDTH-1:0]       wr1_data,
    input  logic                        wr1_enable,
    input  logic [ADDR_WIDTH-1:0]       claim,
    input  logic                        claim_enable,
    output logic [(2**ADDR_WIDTH)-1:0]  busy_vec
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_next;
    logic                  wr_ok;
    logic                  claim_ok;

    // Index 0 is read-only and never busy when it is the hardwired zero register.
    function automatic logic is_zero_idx(input logic [ADDR_WIDTH-1:0] idx);
        return (ZERO_REG != 0) && (idx == '0);
    endfunction

    // Forwarding applies only when the write port targets this read index now.
    function automatic logic fwd_hit(input logic [ADDR_WIDTH-1:0] idx);
        return (BYPASS != 0) && wr1_enable && (wr1 == idx);
    endfunction

    // Read data: reset forces zero, the zero register beats forwarding.
    function automatic logic [DATA_WIDTH-1:0] read_data(input logic [ADDR_WIDTH-1:0] idx);
        if (reset || is_zero_idx(idx))
            return '0;
        else if (fwd_hit(idx))
            return wr1_data;
        else
            return regs[idx];
    endfunction

    // Read busy: a forwarded operand is valid this cycle, so it is not pending.
    function automatic logic read_busy(input logic [ADDR_WIDTH-1:0] idx);
        if (reset || is_zero_idx(idx) || fwd_hit(idx))
            return 1'b0;
        else
            return busy[idx];
    endfunction

    assign wr_ok    = wr1_enable && !is_zero_idx(wr1);
    assign claim_ok = claim_enable && !is_zero_idx(claim);

    // Next scoreboard: clear on writeback, then set on claim so a new producer wins.
    always_comb begin
        busy_next = busy;
        if (wr_ok)
            busy_next[wr1] = 1'b0;
        if (claim_ok)
            busy_next[claim] = 1'b1;
    end

    // Scoreboard flops; reset discards any in-flight claims.
    always_ff @(posedge clock) begin
        if (reset)
            busy <= '0;
        else
            busy <= busy_next;
    end

    // Register array; reset clears every entry and drops a concurrent write.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wr1] <= wr1_data;
        end
    end

    // Combinational read ports, each resolved independently.
    always_comb begin
        rd1_data = read_data(rd1);
        rd1_busy = read_busy(rd1);
        rd2_data = read_data(rd2);
        rd2_busy = read_busy(rd2);
    end

    assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed test of regfile_sb in three configurations that
// share one stimulus stream: bypass on, bypass off, and zero register on.
module tb_regfile_sb;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  rd1, rd2, wr1, claim;
    logic [15:0] wr1_data;
    logic        wr1_enable, claim_enable;

    logic [15:0] rd1_data_a, rd2_data_a, rd1_data_n, rd2_data_n, rd1_data_z, rd2_data_z;
    logic        rd1_busy_a, rd2_busy_a, rd1_busy_n, rd2_busy_n, rd1_busy_z, rd2_busy_z;
    logic [7:0]  busy_vec_a, busy_vec_n, busy_vec_z;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    regfile_sb #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .BYPASS(1), .ZERO_REG(0)) u_byp (
        .clock(clock), .reset(reset),
        .rd1(rd1), .rd1_data(rd1_data_a), .rd1_busy(rd1_busy_a),
        .rd2(rd2), .rd2_data(rd2_data_a), .rd2_busy(rd2_busy_a),
        .wr1(wr1), .wr1_data(wr1_data), .wr1_enable(wr1_enable),
        .claim(claim), .claim_enable(claim_enable), .busy_vec(busy_vec_a)
    );

    regfile_sb #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .BYPASS(0), .ZERO_REG(0)) u_nobyp (
        .clock(clock), .reset(reset),
        .rd1(rd1), .rd1_data(rd1_data_n), .rd1_busy(rd1_busy_n),
        .rd2(rd2), .rd2_data(rd2_data_n), .rd2_busy(rd2_busy_n),
        .wr1(wr1), .wr1_data(wr1_data), .wr1_enable(wr1_enable),
        .claim(claim), .claim_enable(claim_enable), .busy_vec(busy_vec_n)
    );

    regfile_sb #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .BYPASS(1), .ZERO_REG(1)) u_zero (
        .clock(clock), .reset(reset),
        .rd1(rd1), .rd1_data(rd1_data_z), .rd1_busy(rd1_busy_z),
        .rd2(rd2), .rd2_data(rd2_data_z), .rd2_busy(rd2_busy_z),
        .wr1(wr1), .wr1_data(wr1_data), .wr1_enable(wr1_enable),
        .claim(claim), .claim_enable(claim_enable), .busy_vec(busy_vec_z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge so inputs change away from it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        rd1 = 3'd0; rd2 = 3'd0; wr1 = 3'd0; claim = 3'd0;
        wr1_data = 16'h0000; wr1_enable = 1'b0; claim_enable = 1'b0;
        step();
        reset = 1'b0;

        // Write reg3, then reset clears it
        wr1 = 3'd3; wr1_data = 16'hBEEF; wr1_enable = 1'b1;
        step();
        wr1_enable = 1'b0; rd1 = 3'd3;
        #1;
        check("reg3_written", rd1_data_n, 16'hBEEF);
        reset = 1'b1;
        #1;
        check("rd_forced_in_reset", rd1_data_a, 16'h0000);
        check("busy_forced_in_reset", rd1_busy_a, 1'b0);
        step();
        reset = 1'b0;
        #1;
        check("reg3_after_reset", rd1_data_a, 16'h0000);
        check("busy_vec_after_reset", busy_vec_a, 8'h00);

        // Same-cycle bypass vs no bypass
        wr1 = 3'd5; wr1_data = 16'h1234; wr1_enable = 1'b1; rd1 = 3'd5;
        #1;
        check("bypass_same_cycle", rd1_data_a, 16'h1234);
        check("nobypass_same_cycle", rd1_data_n, 16'h0000);
        step();
        wr1_enable = 1'b0;
        #1;
        check("bypass_next_cycle", rd1_data_a, 16'h1234);
        check("nobypass_next_cycle", rd1_data_n, 16'h1234);

        // Scoreboard lifecycle on reg2
        claim = 3'd2; claim_enable = 1'b1; rd2 = 3'd2;
        #1;
        check("claim_not_visible_yet", rd2_busy_a, 1'b0);
        step();
        claim_enable = 1'b0;
        #1;
        check("busy_vec_claim2", busy_vec_a, 8'h04);
        check("rd2_busy_claimed", rd2_busy_a, 1'b1);
        check("rd2_busy_claimed_nobyp", rd2_busy_n, 1'b1);
        wr1 = 3'd2; wr1_data = 16'h00AA; wr1_enable = 1'b1;
        #1;
        check("rd2_busy_fwd", rd2_busy_a, 1'b0);
        check("rd2_data_fwd", rd2_data_a, 16'h00AA);
        check("rd2_busy_nofwd", rd2_busy_n, 1'b1);
        check("rd2_data_nofwd", rd2_data_n, 16'h0000);
        step();
        wr1_enable = 1'b0;
        #1;
        check("busy_vec_cleared", busy_vec_a, 8'h00);
        check("busy_vec_cleared_nobyp", busy_vec_n, 8'h00);
        check("rd2_data_after_wb_nobyp", rd2_data_n, 16'h00AA);

        // Simultaneous set and clear on busy reg4
        claim = 3'd4; claim_enable = 1'b1;
        step();
        wr1 = 3'd4; wr1_data = 16'h5555; wr1_enable = 1'b1; rd1 = 3'd4;
        #1;
        check("rd1_busy_fwd_reg4", rd1_busy_a, 1'b0);
        check("rd1_busy_nofwd_reg4", rd1_busy_n, 1'b1);
        step();
        claim_enable = 1'b0; wr1_enable = 1'b0;
        #1;
        check("set_wins_busy_vec", busy_vec_a, 8'h10);
        check("set_wins_reg4", rd1_data_a, 16'h5555);
        check("set_wins_rd1_busy", rd1_busy_a, 1'b1);

        // Zero register: write and claim to index 0
        wr1 = 3'd0; wr1_data = 16'hFFFF; wr1_enable = 1'b1;
        claim = 3'd0; claim_enable = 1'b1; rd1 = 3'd0; rd2 = 3'd0;
        #1;
        check("zero_rd1_same_cycle", rd1_data_z, 16'h0000);
        check("normal_rd1_fwd_reg0", rd1_data_a, 16'hFFFF);
        step();
        wr1_enable = 1'b0; claim_enable = 1'b0;
        #1;
        check("zero_rd1_data", rd1_data_z, 16'h0000);
        check("zero_rd2_data", rd2_data_z, 16'h0000);
        check("zero_rd1_busy", rd1_busy_z, 1'b0);
        check("zero_rd2_busy", rd2_busy_z, 1'b0);
        check("zero_busy_vec", busy_vec_z, 8'h10);
        check("normal_reg0_written", rd1_data_a, 16'hFFFF);
        check("normal_busy_vec_reg0", busy_vec_a, 8'h11);
        check("normal_rd2_busy_reg0", rd2_busy_a, 1'b1);

        // Claims in flight, then reset with a concurrent write
        claim = 3'd1; claim_enable = 1'b1;
        step();
        claim = 3'd6;
        step();
        claim = 3'd7;
        step();
        claim_enable = 1'b0;
        #1;
        check("busy_vec_before_reset", busy_vec_a, 8'hD3);
        check("zero_busy_vec_before_reset", busy_vec_z, 8'hD2);
        reset = 1'b1; wr1 = 3'd1; wr1_data = 16'h7777; wr1_enable = 1'b1;
        claim = 3'd3; claim_enable = 1'b1;
        step();
        reset = 1'b0; wr1_enable = 1'b0; claim_enable = 1'b0;
        rd1 = 3'd1; rd2 = 3'd4;
        #1;
        check("midop_busy_vec", busy_vec_a, 8'h00);
        check("midop_busy_vec_nobyp", busy_vec_n, 8'h00);
        check("midop_busy_vec_zero", busy_vec_z, 8'h00);
        check("midop_reg1_lost", rd1_data_a, 16'h0000);
        check("midop_reg1_busy", rd1_busy_a, 1'b0);
        check("midop_reg4_cleared", rd2_data_a, 16'h0000);
        check("midop_reg4_busy_nobyp", rd2_busy_n, 1'b0);
        check("midop_reg1_nobyp", rd1_data_n, 16'h0000);
        check("midop_reg1_busy_nobyp", rd1_busy_n, 1'b0);
        check("midop_reg1_zero", rd1_data_z, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
